// File: rtl/z80_flags_pkg.sv
// Shared definitions for the Z80 F register and its consumers.
//   - Flag bit positions within F ({S,Z,Y,H,X,PV,N,C}, bit7..bit0).
//   - cond_code_t: the eight JP/JR/CALL/RET condition codes.
//   - flag_req_t and flag_update(): the prioritised next-value function
//     for one bank (load > ALU > SCF > CCF).
package z80_flags_pkg;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_Y  = 5;
    localparam int FLAG_H  = 4;
    localparam int FLAG_X  = 3;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

    typedef enum logic [2:0] {
        CC_NZ = 3'd0,
        CC_Z  = 3'd1,
        CC_NC = 3'd2,
        CC_C  = 3'd3,
        CC_PO = 3'd4,
        CC_PE = 3'd5,
        CC_P  = 3'd6,
        CC_M  = 3'd7
    } cond_code_t;

    // Bits that SCF and CCF leave untouched; H, N and C are rewritten.
    localparam logic [7:0] CARRY_OP_KEEP = 8'((1 << FLAG_S) | (1 << FLAG_Z) | (1 << FLAG_Y) |
                                              (1 << FLAG_X) | (1 << FLAG_PV));

    typedef struct packed {
        logic       load;
        logic       alu;
        logic       scf;
        logic       ccf;
        logic [7:0] load_data;
        logic [7:0] alu_flag;
        logic [7:0] alu_mask;
    } flag_req_t;

    // Next value of the active bank; only the highest-priority source applies.
    function automatic logic [7:0] flag_update(input logic [7:0] cur, input flag_req_t req);
        logic [7:0] nxt;
        nxt = cur;
        if (req.load) begin
            nxt = req.load_data;
        end else if (req.alu) begin
            nxt = (req.alu_flag & req.alu_mask) | (cur & ~req.alu_mask);
        end else if (req.scf) begin
            nxt         = cur & CARRY_OP_KEEP;
            nxt[FLAG_C] = 1'b1;
        end else if (req.ccf) begin
            nxt         = cur & CARRY_OP_KEEP;
            nxt[FLAG_H] = cur[FLAG_C];
            nxt[FLAG_C] = ~cur[FLAG_C];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/z80_flag_register_if.sv
// Bus between the execution sequencer and the F register.
//   master: drives write strobes, data and condition select; reads results.
//   slave : the F register itself.
interface z80_flag_register_if;
    import z80_flags_pkg::*;

    logic       alu_flag_valid;
    logic [7:0] alu_status_flag;
    logic [7:0] alu_flag_mask;
    logic       load_valid;
    logic [7:0] load_data;
    logic       scf;
    logic       ccf;
    logic       exchange;
    cond_code_t cc_select;
    logic       cc_true;
    logic       carry_out;
    logic [7:0] flags_out;
    logic [7:0] flags_shadow;
    logic       conflict;

    modport master (
        output alu_flag_valid, alu_status_flag, alu_flag_mask,
        output load_valid, load_data, scf, ccf, exchange, cc_select,
        input  cc_true, carry_out, flags_out, flags_shadow, conflict
    );

    modport slave (
        input  alu_flag_valid, alu_status_flag, alu_flag_mask,
        input  load_valid, load_data, scf, ccf, exchange, cc_select,
        output cc_true, carry_out, flags_out, flags_shadow, conflict
    );

endinterface

// File: rtl/z80_cond_eval.sv
// Combinational Z80 condition-code evaluator.
//   cc_select : condition (NZ, Z, NC, C, PO, PE, P, M)
//   flags     : F value to test
//   cc_true   : 1 when the selected condition holds
module z80_cond_eval
    import z80_flags_pkg::*;
(
    input  cond_code_t cc_select,
    input  logic [7:0] flags,
    output logic       cc_true
);

    // Only S, Z, PV and C take part in condition codes.
    logic unused_flags;
    assign unused_flags = ^{flags[FLAG_Y], flags[FLAG_H], flags[FLAG_X], flags[FLAG_N]};

    always_comb begin
        // NOTE: a default assignment first means every path drives cc_true,
        // so no latch is inferred even if a case arm is later removed.
        cc_true = 1'b0;
        unique case (cc_select)
            CC_NZ: cc_true = ~flags[FLAG_Z];
            CC_Z:  cc_true =  flags[FLAG_Z];
            CC_NC: cc_true = ~flags[FLAG_C];
            CC_C:  cc_true =  flags[FLAG_C];
            CC_PO: cc_true = ~flags[FLAG_PV];
            CC_PE: cc_true =  flags[FLAG_PV];
            CC_P:  cc_true = ~flags[FLAG_S];
            CC_M:  cc_true =  flags[FLAG_S];
        endcase
    end

endmodule

// File: rtl/z80_flag_register.sv
// Architectural F register with EX AF,AF' shadow bank.
//   clk   : clock, state updates on rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of z80_flag_register_if
//     inputs : alu_flag_valid/alu_status_flag/alu_flag_mask, load_valid/load_data,
//              scf, ccf, exchange, cc_select
//     outputs: cc_true, carry_out (combinational), flags_out, flags_shadow,
//              conflict (registered one-cycle pulse)
// Parameters:
//   RESET_VALUE : both banks after reset
//   BYPASS      : 1 = cc_true/carry_out see the value the active bank will hold
//                 after this edge; 0 = they see registered flags_out only
module z80_flag_register
    import z80_flags_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'hFF,
    parameter bit         BYPASS      = 1'b1
) (
    input logic               clk,
    input logic               reset,
    z80_flag_register_if.slave bus
);

    logic [7:0] bank0;
    logic [7:0] bank1;
    logic       bank_sel;
    logic       conflict_q;

    logic [7:0] active_cur;
    logic [7:0] shadow_cur;
    logic [7:0] active_next;
    logic [7:0] bypass_view;
    logic [7:0] cond_view;
    logic       multi_src;
    flag_req_t  req;

    assign active_cur = bank_sel ? bank1 : bank0;
    assign shadow_cur = bank_sel ? bank0 : bank1;

    assign req = '{
        load:      bus.load_valid,
        alu:       bus.alu_flag_valid,
        scf:       bus.scf,
        ccf:       bus.ccf,
        load_data: bus.load_data,
        alu_flag:  bus.alu_status_flag,
        alu_mask:  bus.alu_flag_mask
    };

    assign active_next = flag_update(active_cur, req);

    // Two or more write sources in one cycle; all but the winner are dropped.
    assign multi_src = (bus.load_valid     & (bus.alu_flag_valid | bus.scf | bus.ccf)) |
                       (bus.alu_flag_valid & (bus.scf | bus.ccf)) |
                       (bus.scf & bus.ccf);

    // On exchange the written bank becomes the shadow, so the post-edge active
    // value is the old shadow, not the write result.
    assign bypass_view = bus.exchange ? shadow_cur : active_next;
    assign cond_view   = BYPASS ? bypass_view : active_cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank0      <= RESET_VALUE;
            bank1      <= RESET_VALUE;
            bank_sel   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so the bank write below uses
            // the pre-edge bank_sel, sending a same-cycle write to the pre-swap bank.
            if (bank_sel) begin
                bank1 <= active_next;
            end else begin
                bank0 <= active_next;
            end
            bank_sel   <= bank_sel ^ bus.exchange;
            conflict_q <= multi_src;
        end
    end

    z80_cond_eval u_cond_eval (
        .cc_select (bus.cc_select),
        .flags     (cond_view),
        .cc_true   (bus.cc_true)
    );

    assign bus.carry_out    = cond_view[FLAG_C];
    assign bus.flags_out    = active_cur;
    assign bus.flags_shadow = shadow_cur;
    assign bus.conflict     = conflict_q;

endmodule

// File: tb/tb_z80_flag_register.sv
// Directed testbench for z80_flag_register (default parameters).
module tb_z80_flag_register;
    import z80_flags_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    z80_flag_register_if ifc ();

    z80_flag_register dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        ifc.alu_flag_valid  = 1'b0;
        ifc.alu_status_flag = 8'h00;
        ifc.alu_flag_mask   = 8'h00;
        ifc.load_valid      = 1'b0;
        ifc.load_data       = 8'h00;
        ifc.scf             = 1'b0;
        ifc.ccf             = 1'b0;
        ifc.exchange        = 1'b0;
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Build non-reset state: flags 00 and a conflict pulse.
        idle();
        ifc.load_valid     = 1'b1;
        ifc.load_data      = 8'h00;
        ifc.alu_flag_valid = 1'b1;
        ifc.alu_status_flag = 8'h41;
        ifc.alu_flag_mask  = 8'hFF;
        step();
        idle();
        ifc.scf       = 1'b1;
        ifc.cc_select = CC_M;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ifc.flags_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_flags_out got %h want ff", ifc.flags_out);
        end
        checks++;
        if (ifc.flags_shadow !== 8'hFF) begin
            errors++;
            $display("FAIL reset_flags_shadow got %h want ff", ifc.flags_shadow);
        end
        checks++;
        if (ifc.conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_conflict got %b want 0", ifc.conflict);
        end
        step();
        idle();
        reset = 1'b0;
        #1;
        checks++;
        if (ifc.flags_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_discard_scf got %h want ff", ifc.flags_out);
        end
        checks++;
        if (ifc.cc_true !== 1'b1) begin
            errors++;
            $display("FAIL reset_cc_m got %b want 1", ifc.cc_true);
        end
    endtask

    task automatic test_alu_commit();
        idle();
        ifc.alu_flag_valid  = 1'b1;
        ifc.alu_status_flag = 8'b0101_0001;
        ifc.alu_flag_mask   = 8'hFF;
        step();
        idle();
        #1;
        checks++;
        if (ifc.flags_out !== 8'h51) begin
            errors++;
            $display("FAIL alu_flags_out got %h want 51", ifc.flags_out);
        end
        ifc.cc_select = CC_Z;
        #1;
        checks++;
        if (ifc.cc_true !== 1'b1) begin
            errors++;
            $display("FAIL alu_cc_z got %b want 1", ifc.cc_true);
        end
        ifc.cc_select = CC_C;
        #1;
        checks++;
        if (ifc.cc_true !== 1'b1) begin
            errors++;
            $display("FAIL alu_cc_c got %b want 1", ifc.cc_true);
        end
        ifc.cc_select = CC_PE;
        #1;
        checks++;
        if (ifc.cc_true !== 1'b0) begin
            errors++;
            $display("FAIL alu_cc_pe got %b want 0", ifc.cc_true);
        end
    endtask

    task automatic test_mask();
        idle();
        ifc.alu_flag_valid  = 1'b1;
        ifc.alu_status_flag = 8'b1001_0100;
        ifc.alu_flag_mask   = 8'hFE;
        step();
        idle();
        #1;
        checks++;
        if (ifc.flags_out !== 8'h95) begin
            errors++;
            $display("FAIL mask_flags_out got %h want 95", ifc.flags_out);
        end
        checks++;
        if (ifc.carry_out !== 1'b1) begin
            errors++;
            $display("FAIL mask_carry_out got %b want 1", ifc.carry_out);
        end
    endtask

    task automatic test_scf_ccf();
        idle();
        ifc.load_valid = 1'b1;
        ifc.load_data  = 8'h00;
        step();
        idle();
        ifc.scf = 1'b1;
        step();
        idle();
        checks++;
        if (ifc.flags_out !== 8'h01) begin
            errors++;
            $display("FAIL scf_flags_out got %h want 01", ifc.flags_out);
        end
        ifc.ccf = 1'b1;
        step();
        idle();
        #1;
        checks++;
        if (ifc.flags_out !== 8'h10) begin
            errors++;
            $display("FAIL ccf_flags_out got %h want 10", ifc.flags_out);
        end
        checks++;
        if (ifc.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL ccf_carry_out got %b want 0", ifc.carry_out);
        end
    endtask

    task automatic test_exchange_write();
        idle();
        ifc.load_valid = 1'b1;
        ifc.load_data  = 8'h42;
        step();
        idle();
        ifc.exchange   = 1'b1;
        ifc.load_valid = 1'b1;
        ifc.load_data  = 8'h13;
        ifc.cc_select  = CC_P;
        #1;
        // Bypass must show the old shadow FF (S=1), not 42 or 13 (S=0).
        checks++;
        if (ifc.cc_true !== 1'b0) begin
            errors++;
            $display("FAIL exch_bypass_cc_p got %b want 0", ifc.cc_true);
        end
        step();
        idle();
        #1;
        checks++;
        if (ifc.flags_out !== 8'hFF) begin
            errors++;
            $display("FAIL exch_flags_out got %h want ff", ifc.flags_out);
        end
        checks++;
        if (ifc.flags_shadow !== 8'h13) begin
            errors++;
            $display("FAIL exch_flags_shadow got %h want 13", ifc.flags_shadow);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        ifc.exchange = 1'b1;
        step();
        checks++;
        if (ifc.flags_out !== 8'h13 || ifc.flags_shadow !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_first got %h/%h want 13/ff", ifc.flags_out, ifc.flags_shadow);
        end
        step();
        idle();
        checks++;
        if (ifc.flags_out !== 8'hFF || ifc.flags_shadow !== 8'h13) begin
            errors++;
            $display("FAIL b2b_second got %h/%h want ff/13", ifc.flags_out, ifc.flags_shadow);
        end
    endtask

    task automatic test_conflict_bypass();
        idle();
        ifc.load_valid      = 1'b1;
        ifc.load_data       = 8'h00;
        ifc.alu_flag_valid  = 1'b1;
        ifc.alu_status_flag = 8'h41;
        ifc.alu_flag_mask   = 8'hFF;
        ifc.cc_select       = CC_Z;
        #1;
        checks++;
        if (ifc.cc_true !== 1'b0) begin
            errors++;
            $display("FAIL conflict_bypass_cc_z got %b want 0", ifc.cc_true);
        end
        step();
        idle();
        checks++;
        if (ifc.flags_out !== 8'h00) begin
            errors++;
            $display("FAIL conflict_flags_out got %h want 00", ifc.flags_out);
        end
        checks++;
        if (ifc.conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_pulse got %b want 1", ifc.conflict);
        end
        step();
        checks++;
        if (ifc.conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_clear got %b want 0", ifc.conflict);
        end
        // SCF beats CCF.
        ifc.scf = 1'b1;
        ifc.ccf = 1'b1;
        step();
        idle();
        checks++;
        if (ifc.flags_out !== 8'h01 || ifc.conflict !== 1'b1) begin
            errors++;
            $display("FAIL scf_ccf_priority got %h/%b want 01/1", ifc.flags_out, ifc.conflict);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        ifc.cc_select = CC_NZ;
        idle();
        #12;
        reset = 1'b0;
        step();
        test_reset();
        test_alu_commit();
        test_mask();
        test_scf_ccf();
        test_exchange_write();
        test_back_to_back();
        test_conflict_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
